calculadora_preco_seq: RTL and testbench
========================================

CALCULADORA_PRECO_SEQ -- requirements
Module: calculadora_preco_seq

Interface
REQ-001 SHALL have parameter W_PESO, default 14, width of gross weight in grams.
REQ-002 SHALL have parameter W_PRECO, default 9, width of unit price in cents per kg.
REQ-003 SHALL have parameter W_TOT, default 20, width of accumulated total in cents.
REQ-004 SHALL have parameter TARA_DEFAULT, default 40, tare in grams loaded at reset.
REQ-005 SHALL use derived widths W_PROD = W_PESO+W_PRECO and W_CENT = W_PROD-9; they are not user parameters.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a price calculation.
- pesoemgramas  in  W_PESO  gross weight, sampled with start.
- centimos  in  W_PRECO  price per kg, sampled with start.
- acumular  in  1  add the result to the total, sampled with start.
- tara_load  in  1  load tare register.
- tara_in  in  W_PESO  new tare value.
- limpar_total  in  1  clear total and overflow.
- busy  out  1  calculation in progress.
- done  out  1  one-cycle result-valid pulse.
- precofinalinteiro  out  W_CENT  euros.
- precofinalfracao  out  7  cents, 0..99.
- abaixo_tara  out  1  gross weight was below tare.
- total_cent  out  W_TOT  running total in cents.
- total_ovf  out  1  sticky total saturation flag.

Function
REQ-007 SHALL use FSM states IDLE, MUL, DIV1, DIV2, DONE; all transitions on clk rising edge.
REQ-008 SHALL, in IDLE with start=1, capture net = pesoemgramas-tara, or 0 if pesoemgramas<tara, capture centimos and acumular, set abaixo_tara, and enter MUL.
REQ-009 SHALL, in MUL, form product = centimos*net, exact in W_PROD bits, by shift-add over exactly W_PRECO cycles, then enter DIV1.
REQ-010 SHALL, in DIV1, compute cents = floor(product/1000) by restoring division over exactly W_PROD cycles, then enter DIV2.
REQ-011 SHALL, in DIV2, compute euros = floor(cents/100) and frac = cents mod 100 over exactly W_CENT cycles, then enter DONE.
REQ-012 SHALL, in DONE, hold done=1 for one cycle, update precofinalinteiro and precofinalfracao, and return to IDLE.
REQ-013 SHALL assert done exactly W_PRECO+W_PROD+W_CENT+1 edges after the edge sampling start; this is 47 edges at default widths.
REQ-014 SHALL assert busy=1 in MUL, DIV1, DIV2 and DONE, and busy=0 in IDLE.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL hold result outputs and abaixo_tara stable from DONE until the next DONE.
REQ-017 SHALL load tara_in into tare on any cycle with tara_load=1, including while busy.
REQ-018 SHALL leave an in-flight calculation unaffected by a tare load, because net is already captured.
REQ-019 SHALL, when tara_load and start occur in the same cycle, compute net with the old tare.
REQ-020 SHALL, in DONE with captured acumular=1, set total_cent = total_cent+cents.
REQ-021 SHALL saturate total_cent to 2^W_TOT-1 and set total_ovf=1 when the sum exceeds 2^W_TOT-1.
REQ-022 SHALL hold total_ovf at 1 until limpar_total or reset.
REQ-023 SHALL, on limpar_total=1, clear total_cent and total_ovf to 0 synchronously.
REQ-024 SHALL give limpar_total priority when it coincides with an accumulation in DONE: result is 0 and the item is discarded.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force state IDLE, busy=0, done=0, precofinalinteiro=0, precofinalfracao=0, abaixo_tara=0, total_cent=0, total_ovf=0, and tare=TARA_DEFAULT.
REQ-026 SHALL abort any in-flight calculation on reset, with no done pulse and no accumulation, and SHALL accept start on the first edge after rst falls.

Verification
REQ-027 SHALL cover: tare 40, peso=1040, centimos=250, acumular=1 -> done at edge 47, inteiro=2, fracao=50, total_cent=250.
REQ-028 SHALL cover: tare 40, peso=30, centimos=511 -> inteiro=0, fracao=0, abaixo_tara=1.
REQ-029 SHALL cover: tara_load with tara_in=0, then peso=16383, centimos=511, acumular=1 -> inteiro=83, fracao=71, total_cent rises from 250 to 8621.
REQ-030 SHALL cover: W_TOT=12, accumulate 8371 cents -> total_cent=4095, total_ovf=1, then limpar_total -> total_cent=0, total_ovf=0.
REQ-031 SHALL cover: start, rst pulse at edge 20, then start asserted repeatedly while busy -> no done from the aborted run, outputs 0, tare 40, exactly one done per accepted start.
REQ-032 SHALL cover: tara_load with tara_in=100 in the same cycle as start with peso=1040, centimos=250 -> result uses tare 40 (2 euros, 50 cents); the next start uses tare 100.

Source files
------------

// File: rtl/calculadora_preco_seq.sv
// Sequential price calculator for a weighing scale.
// A start request captures the net weight (gross minus tare) and the price per kg.
// The datapath then runs three fixed-length phases:
//   - a shift-add multiply (price * net),
//   - a restoring divide by 1000 (grams*cents/kg -> cents),
//   - a restoring divide by 100 (cents -> euros + cents).
// Each phase has a fixed length, so the result latency is constant.
// Results can optionally be accumulated into a saturating running total.
//
// Handshake: start is sampled only while busy=0. busy rises on the edge that
// accepts start and falls on the edge that raises done. done is a one-cycle
// pulse. The result outputs are valid from that pulse until the next one.
module calculadora_preco_seq #(
  parameter int W_PESO       = 14,
  parameter int W_PRECO      = 9,
  parameter int W_TOT        = 20,
  parameter int TARA_DEFAULT = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [W_PESO-1:0]         pesoemgramas,
  input  logic [W_PRECO-1:0]        centimos,
  input  logic                      acumular,
  input  logic                      tara_load,
  input  logic [W_PESO-1:0]         tara_in,
  input  logic                      limpar_total,
  output logic                      busy,
  output logic                      done,
  output logic [W_PESO+W_PRECO-10:0] precofinalinteiro,
  output logic [6:0]                precofinalfracao,
  output logic                      abaixo_tara,
  output logic [W_TOT-1:0]          total_cent,
  output logic                      total_ovf
);

  localparam int W_PROD = W_PESO + W_PRECO;
  localparam int W_CENT = W_PROD - 9;
  localparam int W_CNT  = $clog2(W_PROD + 1);
  localparam int W_SUM  = ((W_TOT > W_CENT) ? W_TOT : W_CENT) + 1;

  localparam logic [W_CNT-1:0] CNT_MUL  = W_CNT'(W_PRECO - 1);
  localparam logic [W_CNT-1:0] CNT_DIV1 = W_CNT'(W_PROD - 1);
  localparam logic [W_CNT-1:0] CNT_DIV2 = W_CNT'(W_CENT - 1);
  localparam logic [W_SUM-1:0] TOT_MAX  = W_SUM'({W_TOT{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV1 = 3'd2,
    S_DIV2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  logic [W_CNT-1:0]    r_cnt;
  logic [W_PESO-1:0]   r_tara;
  logic [W_PROD-1:0]   r_mcand;
  logic [W_PRECO-1:0]  r_mplier;
  logic [W_PROD-1:0]   r_prod;
  logic [9:0]          r_rem1;
  logic [W_CENT-1:0]   r_cents;
  logic [W_CENT-1:0]   r_cents_keep;
  logic [6:0]          r_rem2;
  logic                r_acc;
  logic                r_abaixo;

  logic                w_abaixo;
  logic [W_PESO-1:0]   w_net;
  logic [10:0]         w_trial1;
  logic                w_bit1;
  logic [9:0]          w_rem1_nx;
  logic [W_PROD-1:0]   w_prod_shift;
  logic [7:0]          w_trial2;
  logic                w_bit2;
  logic [6:0]          w_rem2_nx;
  logic [W_CENT-1:0]   w_cents_shift;
  logic [W_SUM-1:0]    w_sum;

  // Net weight and one restoring-division step for each divider phase.
  always_comb begin
    w_abaixo      = (pesoemgramas < r_tara);
    w_net         = w_abaixo ? '0 : (pesoemgramas - r_tara);
    // Divide by 1000: the remainder stays below 1000, so the trial value fits in 11 bits.
    w_trial1      = {r_rem1, r_prod[W_PROD-1]};
    w_bit1        = (w_trial1 >= 11'd1000);
    w_rem1_nx     = w_bit1 ? 10'(w_trial1 - 11'd1000) : w_trial1[9:0];
    w_prod_shift  = {r_prod[W_PROD-2:0], w_bit1};
    // Divide by 100: the remainder stays below 100, so the trial value fits in 8 bits.
    w_trial2      = {r_rem2, r_cents[W_CENT-1]};
    w_bit2        = (w_trial2 >= 8'd100);
    w_rem2_nx     = w_bit2 ? 7'(w_trial2 - 8'd100) : w_trial2[6:0];
    w_cents_shift = {r_cents[W_CENT-2:0], w_bit2};
    w_sum         = W_SUM'(total_cent) + W_SUM'(r_cents_keep);
  end

  // Tare register; loads at any time. A load is not seen by a start in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tara <= W_PESO'(TARA_DEFAULT);
    else if (tara_load) r_tara <= tara_in;
  end

  // Control FSM and arithmetic datapath, with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_mcand           <= '0;
      r_mplier          <= '0;
      r_prod            <= '0;
      r_rem1            <= '0;
      r_cents           <= '0;
      r_cents_keep      <= '0;
      r_rem2            <= '0;
      r_acc             <= 1'b0;
      r_abaixo          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      precofinalinteiro <= '0;
      precofinalfracao  <= '0;
      abaixo_tara       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= W_PROD'(w_net);
            r_mplier <= centimos;
            r_prod   <= '0;
            r_acc    <= acumular;
            r_abaixo <= w_abaixo;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first; the product cannot exceed W_PROD bits.
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CNT_MUL) begin
            r_cnt   <= '0;
            r_rem1  <= '0;
            r_state <= S_DIV1;
          end else begin
            r_cnt <= r_cnt + W_CNT'(1);
          end
        end
        S_DIV1: begin
          r_prod <= w_prod_shift;
          r_rem1 <= w_rem1_nx;
          if (r_cnt == CNT_DIV1) begin
            // The quotient is below 2^W_CENT, so the upper bits are always zero.
            r_cents      <= w_prod_shift[W_CENT-1:0];
            r_cents_keep <= w_prod_shift[W_CENT-1:0];
            r_rem2       <= '0;
            r_cnt        <= '0;
            r_state      <= S_DIV2;
          end else begin
            r_cnt <= r_cnt + W_CNT'(1);
          end
        end
        S_DIV2: begin
          r_cents <= w_cents_shift;
          r_rem2  <= w_rem2_nx;
          if (r_cnt == CNT_DIV2) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + W_CNT'(1);
          end
        end
        S_DONE: begin
          precofinalinteiro <= r_cents;
          precofinalfracao  <= r_rem2;
          abaixo_tara       <= r_abaixo;
          done              <= 1'b1;
          busy              <= 1'b0;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Running total. A clear wins over an accumulation in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cent <= '0;
      total_ovf  <= 1'b0;
    end else if (limpar_total) begin
      total_cent <= '0;
      total_ovf  <= 1'b0;
    end else if ((r_state == S_DONE) && r_acc) begin
      if (w_sum > TOT_MAX) begin
        total_cent <= {W_TOT{1'b1}};
        total_ovf  <= 1'b1;
      end else begin
        total_cent <= w_sum[W_TOT-1:0];
      end
    end
  end

endmodule

// File: tb/tb_calculadora_preco_seq.sv
// Randomized + directed bench for calculadora_preco_seq.
// Each driven request pushes its expected result into exp_q.
// A negedge monitor pops the queue and compares whenever done is high.
module tb_calculadora_preco_seq;

  localparam int  LAT     = 47;
  localparam longint TMAX = 64'd1048575;

  logic        clk;
  logic        rst;
  logic        start, acumular, tara_load, limpar_total;
  logic [13:0] pesoemgramas, tara_in;
  logic [8:0]  centimos;
  logic        busy, done, abaixo_tara, total_ovf;
  logic [13:0] precofinalinteiro;
  logic [6:0]  precofinalfracao;
  logic [19:0] total_cent;

  // Second instance with a narrow total, for saturation.
  logic        b_start, b_acumular, b_tara_load, b_limpar;
  logic [13:0] b_peso, b_tara_in;
  logic [8:0]  b_cent;
  logic        b_busy, b_done, b_abaixo, b_ovf;
  logic [13:0] b_inteiro;
  logic [6:0]  b_fracao;
  logic [11:0] b_total;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected-record layout: {done_cycle[31:0], inteiro[13:0], fracao[6:0], abaixo, total[19:0], ovf}
  logic [74:0] exp_q[$];

  // Reference model state.
  int     m_tara  = 40;
  longint m_total = 0;
  bit     m_ovf   = 0;

  calculadora_preco_seq dut (
    .clk(clk), .rst(rst), .start(start), .pesoemgramas(pesoemgramas),
    .centimos(centimos), .acumular(acumular), .tara_load(tara_load),
    .tara_in(tara_in), .limpar_total(limpar_total), .busy(busy), .done(done),
    .precofinalinteiro(precofinalinteiro), .precofinalfracao(precofinalfracao),
    .abaixo_tara(abaixo_tara), .total_cent(total_cent), .total_ovf(total_ovf)
  );

  calculadora_preco_seq #(.W_TOT(12), .TARA_DEFAULT(0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pesoemgramas(b_peso),
    .centimos(b_cent), .acumular(b_acumular), .tara_load(b_tara_load),
    .tara_in(b_tara_in), .limpar_total(b_limpar), .busy(b_busy), .done(b_done),
    .precofinalinteiro(b_inteiro), .precofinalfracao(b_fracao),
    .abaixo_tara(b_abaixo), .total_cent(b_total), .total_ovf(b_ovf)
  );

  // Clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one queued record per done pulse, including the cycle it should appear on.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [74:0] e;
        e = exp_q.pop_front();
        check("done_latency", cyc,               e[74:43]);
        check("inteiro",      precofinalinteiro, e[42:29]);
        check("fracao",       precofinalfracao,  e[28:22]);
        check("abaixo_tara",  abaixo_tara,       e[21]);
        check("total_cent",   total_cent,        e[20:1]);
        check("total_ovf",    total_ovf,         e[0]);
        check("busy_at_done", busy,              0);
      end
    end
  end

  // Driver: one price request.
  // tmode: 0 = no tare load, 1 = tare load in the start cycle,
  //        2 = tare load mid-calculation.
  // hold keeps start asserted for extra cycles while busy.
  task automatic do_calc(input int peso, input int cent, input bit acc, input int tmode,
                         input int tin, input bit clr_done, input int hold, input bit nowait);
    int     t0, net, cents;
    bit     ab;
    if (!nowait) @(negedge clk);
    ab    = (peso < m_tara);
    net   = ab ? 0 : peso - m_tara;
    cents = (cent * net) / 1000;
    if (clr_done) begin
      m_total = 0;
      m_ovf   = 0;
    end else if (acc) begin
      m_total = m_total + cents;
      if (m_total > TMAX) begin
        m_total = TMAX;
        m_ovf   = 1;
      end
    end
    pesoemgramas = 14'(peso);
    centimos     = 9'(cent);
    acumular     = acc;
    start        = 1'b1;
    tara_load    = (tmode == 1);
    tara_in      = 14'(tin);
    @(negedge clk);
    t0        = cyc;
    tara_load = 1'b0;
    if (hold == 0) start = 1'b0;
    exp_q.push_back({32'(t0 + LAT), 14'(cents / 100), 7'(cents % 100), ab, 20'(m_total), m_ovf});
    if (tmode == 1) m_tara = tin;
    check("busy_after_start", busy, 1);
    for (int k = 1; k < 120 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      start        = (k < hold);
      tara_load    = (tmode == 2 && k == 10);
      limpar_total = (clr_done && k == 46);
    end
    start = 1'b0; tara_load = 1'b0; limpar_total = 1'b0;
    if (tmode == 2) m_tara = tin;
    if (exp_q.size() != 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic load_tare(input int v);
    @(negedge clk);
    tara_load = 1'b1; tara_in = 14'(v);
    @(negedge clk);
    tara_load = 1'b0;
    m_tara = v;
  endtask

  task automatic clear_total();
    @(negedge clk);
    limpar_total = 1'b1;
    @(negedge clk);
    limpar_total = 1'b0;
    m_total = 0; m_ovf = 0;
    check("clear_total", total_cent, 0);
    check("clear_ovf",   total_ovf,  0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    busy,              0);
    check({tag, "_done"},    done,              0);
    check({tag, "_inteiro"}, precofinalinteiro, 0);
    check({tag, "_fracao"},  precofinalfracao,  0);
    check({tag, "_abaixo"},  abaixo_tara,       0);
    check({tag, "_total"},   total_cent,        0);
    check({tag, "_ovf"},     total_ovf,         0);
  endtask

  initial begin
    int t0, p, found;
    rst = 1'b1; start = 0; acumular = 0; tara_load = 0; limpar_total = 0;
    pesoemgramas = 0; centimos = 0; tara_in = 0;
    b_start = 0; b_acumular = 0; b_tara_load = 0; b_limpar = 0;
    b_peso = 0; b_cent = 0; b_tara_in = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases.
    do_calc(1040, 250, 1, 0, 0, 0, 0, 0);      // 2.50, total 250
    do_calc(30, 511, 0, 0, 0, 0, 0, 0);        // below tare -> 0.00
    load_tare(0);
    do_calc(16383, 511, 1, 0, 0, 0, 0, 0);     // 83.71, total 8621
    load_tare(40);
    do_calc(1040, 250, 0, 1, 100, 0, 0, 0);    // same-cycle load uses old tare
    do_calc(1040, 250, 0, 0, 0, 0, 0, 0);      // now tare 100 -> 2.35
    do_calc(2000, 400, 1, 0, 0, 1, 0, 0);      // clear coincident with accumulation wins
    do_calc(5000, 300, 1, 2, 7, 0, 0, 0);      // mid-flight tare load ignored by this run
    do_calc(5000, 300, 1, 0, 0, 0, 30, 0);     // start held while busy, tare 7

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 16383);
      do_calc(p, $urandom_range(0, 511), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              $urandom_range(0, 300), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0, 0);
      if ($urandom_range(0, 9) == 0) clear_total();
    end

    // Reset in the middle of a calculation.
    @(negedge clk);
    pesoemgramas = 14'd9000; centimos = 9'd300; acumular = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t0 = cyc;
    while (cyc < t0 + 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    m_tara = 40; m_total = 0; m_ovf = 0;
    // Start on the first edge after reset is released, and keep it asserted while busy.
    do_calc(1040, 250, 1, 0, 0, 0, 40, 1);
    repeat (5) @(negedge clk);
    check("no_extra_done_q", exp_q.size(), 0);

    // Saturation on the narrow-total instance: 8371 cents into a 12-bit total.
    @(negedge clk);
    b_peso = 14'd16383; b_cent = 9'd511; b_acumular = 1'b1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(negedge clk);
      if (b_done) found = 1;
    end
    check("sat_done_seen", found, 1);
    check("sat_inteiro", b_inteiro, 83);
    check("sat_fracao",  b_fracao,  71);
    check("sat_total",   b_total,   4095);
    check("sat_ovf",     b_ovf,     1);
    repeat (3) @(negedge clk);
    check("sat_ovf_sticky", b_ovf, 1);
    b_limpar = 1'b1;
    @(negedge clk);
    b_limpar = 1'b0;
    check("sat_clear_total", b_total, 0);
    check("sat_clear_ovf",   b_ovf,   0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
